// File: rtl/adc_uart_packer_if.sv
// Sample-in / character-out handshake bundle between the ADC register, the packer and uart_tx.
// The master side is the packer; the slave side is whatever feeds samples and owns tx_rdy.
interface adc_uart_packer_if #(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned N_data   = 6
);
  logic                smp_valid;
  logic [SAMPLE_W-1:0] smp_data;
  logic                tx_rdy;
  logic                tx_wreq;
  logic [N_data-1:0]   tx_wdata;

  modport master (
    input  smp_valid,
    input  smp_data,
    input  tx_rdy,
    output tx_wreq,
    output tx_wdata
  );

  modport slave (
    output smp_valid,
    output smp_data,
    output tx_rdy,
    input  tx_wreq,
    input  tx_wdata
  );
endinterface

// File: rtl/adc_uart_packer.sv
// Buffers ADC samples in a small FIFO and emits each one as NCHUNK UART characters,
// most significant slice first, with a frame-start flag in the MSB of the first character.
module adc_uart_packer #(
  parameter int unsigned SAMPLE_W   = 10,
  parameter int unsigned N_data     = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  adc_uart_packer_if.master           bus,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  ovf_cnt
);

  localparam int unsigned PayW   = N_data - 1;
  localparam int unsigned NCHUNK = (SAMPLE_W + PayW - 1) / PayW;
  localparam int unsigned PadW   = NCHUNK * PayW;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [PtrW:0]   FullCnt = FIFO_DEPTH[PtrW:0];
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StIssue
  } state_e;

  // FIFO storage and bookkeeping
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q;
  logic [7:0]          ovf_q;
  logic                fifo_full, fifo_empty;
  logic                push, pop, drop;

  // Character sequencer
  state_e            state_q, state_d;
  logic [PadW-1:0]   shreg_q, shreg_d;
  logic [IdxW-1:0]   chunk_q, chunk_d;
  logic              wreq_q, wreq_d;
  logic [N_data-1:0] wdata_q, wdata_d;

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == StIdle) && !fifo_empty;
  // A pop frees the head slot on the same edge, so a full FIFO can still take a sample.
  assign push       = bus.smp_valid && (!fifo_full || pop);
  assign drop       = bus.smp_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.smp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop && (ovf_q != 8'hFF)) begin
        ovf_q <= ovf_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      chunk_q <= '0;
      wreq_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      chunk_q <= chunk_d;
      wreq_q  <= wreq_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    chunk_d = chunk_q;
    wreq_d  = 1'b0;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          shreg_d = PadW'(mem_q[rd_ptr_q]);
          chunk_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (bus.tx_rdy) begin
          wreq_d  = 1'b1;
          wdata_d = {(chunk_q == '0), shreg_q[PadW-1 -: PayW]};
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (chunk_q != LastIdx) begin
          chunk_d = chunk_q + 1'b1;
          shreg_d = shreg_q << PayW;
          state_d = StSend;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.tx_wreq  = wreq_q;
  assign bus.tx_wdata = wdata_q;
  assign busy         = (state_q != StIdle) || !fifo_empty;
  assign fifo_level   = count_q;
  assign ovf_cnt      = ovf_q;

endmodule

// File: tb/tb_adc_uart_packer.sv
// Directed bench for adc_uart_packer: latency, back-pressure, burst overflow, push-on-pop,
// mid-transfer reset and full-scale character packing.
module tb_adc_uart_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] fifo_level;
  logic [7:0] ovf_cnt;
  int         n_checks = 0;
  int         n_pass   = 0;

  adc_uart_packer_if #(.SAMPLE_W(10), .N_data(6)) bus ();

  adc_uart_packer #(
    .SAMPLE_W  (10),
    .N_data    (6),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .fifo_level(fifo_level),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until tx_wreq is seen; n is the number of cycles taken, or -1 on timeout.
  task automatic wait_wreq(output logic [5:0] d, output int n);
    d = '0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (bus.tx_wreq === 1'b1) begin
        d = bus.tx_wdata;
        n = i;
        return;
      end
    end
  endtask

  task automatic push_one(input logic [9:0] v);
    bus.smp_valid = 1'b1;
    bus.smp_data  = v;
    tick();
    bus.smp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (bus.tx_wreq !== 1'b0) $display("FAIL reset_wreq: got %b want 0", bus.tx_wreq); else n_pass++;
    n_checks++; if (bus.tx_wdata !== 6'h00) $display("FAIL reset_wdata: got %h want 00", bus.tx_wdata); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (ovf_cnt !== 8'd0) $display("FAIL reset_ovf: got %0d want 0", ovf_cnt); else n_pass++;
  endtask

  task automatic test_single_backpressure();
    bit saw;
    logic [5:0] d;
    int n;
    bus.tx_rdy = 1'b1;
    push_one(10'h2AB);  // now in cycle c+1
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (fifo_level !== 3'd1) $display("FAIL single_level: got %0d want 1", fifo_level); else n_pass++;
    tick();  // c+2
    n_checks++; if (bus.tx_wreq !== 1'b0) $display("FAIL single_early_wreq: got %b want 0", bus.tx_wreq); else n_pass++;
    tick();  // c+3
    n_checks++; if (bus.tx_wreq !== 1'b1) $display("FAIL single_latency: wreq got %b want 1", bus.tx_wreq); else n_pass++;
    n_checks++; if (bus.tx_wdata !== 6'h35) $display("FAIL single_char0: got %h want 35", bus.tx_wdata); else n_pass++;
    bus.tx_rdy = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.tx_wreq !== 1'b0) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) $display("FAIL bp_no_wreq: got %b want 0", saw); else n_pass++;
    bus.tx_rdy = 1'b1;
    wait_wreq(d, n);
    n_checks++; if (n != 1) $display("FAIL bp_release_latency: got %0d want 1", n); else n_pass++;
    n_checks++; if (d !== 6'h0B) $display("FAIL single_char1: got %h want 0b", d); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++; if (bus.tx_wdata !== 6'h0B) $display("FAIL single_wdata_hold: got %h want 0b", bus.tx_wdata); else n_pass++;
  endtask

  task automatic test_burst_overflow();
    logic [5:0] d;
    int n;
    logic [5:0] exp_lo [5] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h06};
    bus.tx_rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.smp_valid = 1'b1;
      bus.smp_data  = 10'(k);
      tick();
    end
    bus.smp_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd4) $display("FAIL burst_level: got %0d want 4", fifo_level); else n_pass++;
    n_checks++; if (ovf_cnt !== 8'd1) $display("FAIL burst_ovf: got %0d want 1", ovf_cnt); else n_pass++;
    bus.tx_rdy = 1'b1;
    wait_wreq(d, n);
    n_checks++; if (n < 0 || d !== 6'h20) $display("FAIL burst_s0_c0: got %h (n=%0d) want 20", d, n); else n_pass++;
    wait_wreq(d, n);
    n_checks++; if (n < 0 || d !== 6'h00) $display("FAIL burst_s0_c1: got %h (n=%0d) want 00", d, n); else n_pass++;
    // Last ISSUE of sample 0 is this cycle; next cycle is IDLE and pops while full.
    tick();
    push_one(10'h006);
    n_checks++; if (fifo_level !== 3'd4) $display("FAIL pushpop_level: got %0d want 4", fifo_level); else n_pass++;
    n_checks++; if (ovf_cnt !== 8'd1) $display("FAIL pushpop_ovf: got %0d want 1", ovf_cnt); else n_pass++;
    for (int s = 0; s < 5; s++) begin
      wait_wreq(d, n);
      n_checks++; if (n < 0 || d !== 6'h20) $display("FAIL burst_order_c0[%0d]: got %h (n=%0d) want 20", s, d, n); else n_pass++;
      wait_wreq(d, n);
      n_checks++; if (n < 0 || d !== exp_lo[s]) $display("FAIL burst_order_c1[%0d]: got %h (n=%0d) want %h", s, d, n, exp_lo[s]); else n_pass++;
    end
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL burst_drain_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [5:0] d;
    int n;
    bus.tx_rdy = 1'b1;
    push_one(10'h155);
    push_one(10'h0AA);
    wait_wreq(d, n);  // first ISSUE cycle of 10'h155
    n_checks++; if (n < 0 || d !== 6'h2A) $display("FAIL midrst_c0: got %h (n=%0d) want 2a", d, n); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.tx_wreq !== 1'b0) $display("FAIL midrst_wreq: got %b want 0", bus.tx_wreq); else n_pass++;
    n_checks++; if (fifo_level !== 3'd0) $display("FAIL midrst_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (ovf_cnt !== 8'd0) $display("FAIL midrst_ovf: got %0d want 0", ovf_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_full_scale();
    logic [5:0] d;
    int n;
    bus.tx_rdy = 1'b1;
    push_one(10'h3FF);
    wait_wreq(d, n);
    n_checks++; if (n != 2) $display("FAIL fs_latency: got %0d want 2", n); else n_pass++;
    n_checks++; if (d !== 6'h3F) $display("FAIL fs_c0: got %h want 3f", d); else n_pass++;
    wait_wreq(d, n);
    n_checks++; if (n != 2) $display("FAIL fs_gap: got %0d want 2", n); else n_pass++;
    n_checks++; if (d !== 6'h1F) $display("FAIL fs_c1: got %h want 1f", d); else n_pass++;
  endtask

  initial begin
    bus.smp_valid = 1'b0;
    bus.smp_data  = '0;
    bus.tx_rdy    = 1'b0;
    test_reset();
    test_single_backpressure();
    test_burst_overflow();
    test_mid_reset();
    test_full_scale();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_uart_packer.md
# adc_uart_packer

Upstream feeder for the UART transmitter (`uart_tx`). It captures ADC conversion results into a small FIFO and splits each sample into fixed-width UART characters, with a frame-start flag in each character's MSB. It drives the transmitter's `wreq`/`wdata`/`rdy` handshake one character at a time. It sits between the ADC output register and `uart_tx`, so the host can stream samples at the 6-bit-per-character link width.

## Interface
- `SAMPLE_W`, 10: ADC sample width.
- `N_data`, 6: UART character width. Must equal `uart_tx` `N_data`. Payload per character is `N_data-1` bits.
- `FIFO_DEPTH`, 4: sample FIFO depth. Power of two, ≥ 2.
- `NCHUNK`, derived: ceil(`SAMPLE_W`/(`N_data`-1)). Default is 2.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `smp_valid`  in  1  one-cycle strobe: `smp_data` holds a new sample.
- `smp_data`  in  `SAMPLE_W`  ADC sample.
- `tx_rdy`  in  1  from `uart_tx` `rdy`. 1 means idle and ready.
- `tx_wreq`  out  1  to `uart_tx` `wreq`. Registered, one-cycle pulse.
- `tx_wdata`  out  `N_data`  to `uart_tx` `wdata`. Registered, stable while `tx_wreq`=1.
- `busy`  out  1  state≠IDLE or FIFO not empty.
- `fifo_level`  out  clog2(`FIFO_DEPTH`)+1  samples queued.
- `ovf_cnt`  out  8  dropped samples, saturating at 255.

## Operation
- **Reset values:** all outputs are 0, the FIFO is empty, and the state is IDLE. When `rst` is high on an edge, everything clears regardless of state. An in-flight character is abandoned: `tx_wreq` is 0 the next cycle.
- **FIFO write:** `smp_valid`=1 and not full pushes `smp_data`. `smp_valid`=1 while full drops the sample and increments `ovf_cnt` (saturating).
  - If full and a pop happen in the same cycle, the write is accepted and the level is unchanged.
- **Character format:**
  - The sample is zero-extended on the MSB side to `NCHUNK`·(`N_data`-1) bits.
  - Character k (k=0 sent first) carries slice k, taken most significant first, in bits [`N_data`-2:0].
  - Bit `N_data`-1 = 1 for k=0, otherwise 0.
- **FSM:**
  - IDLE: if the FIFO is not empty, pop the head into the shift register, set `chunk_idx`=0, and go to SEND.
  - SEND: wait for `tx_rdy`=1. When it is 1, register `tx_wreq`←1 and `tx_wdata`←character `chunk_idx`, and go to ISSUE.
  - ISSUE: `tx_wreq`←0.
    - If `chunk_idx`<`NCHUNK`-1, increment it and go to SEND.
    - Otherwise go to IDLE.
- **Handshake rules:**
  - `tx_wreq` is never high on two consecutive cycles.
  - `tx_wdata` holds its last value between requests.
  - `tx_rdy` is ignored outside SEND.
  - While `uart_tx` is sending a character, its `rdy`=0 holds the FSM in SEND.

## Timing
- **Latency:** a sample strobed in cycle c with an empty FIFO, IDLE state and `tx_rdy`=1 is popped at the end of cycle c+1. `tx_wreq`=1 in cycle c+3, with `tx_wdata`=character 0.
- **Between characters:** a minimum of 2 cycles from an ISSUE cycle to the next ISSUE cycle. In practice this is bounded by the UART frame time, (1+`N_data`+1)·FREQ/BAUDRATE clocks.
- **Between samples:** ISSUE of the last character → IDLE → pop, so the next character 0 appears no earlier than 3 cycles after the previous last-character ISSUE.
- **Throughput:** sustained input rate must be ≤ one sample per `NCHUNK` UART frames. Excess input fills the FIFO, after which `ovf_cnt` counts drops.
- **`fifo_level`:** updates the cycle after a push or pop.
- **`busy`:** goes high the cycle after the first push. It returns to 0 the cycle after the last ISSUE when the FIFO is empty.

## Test plan
- **Single sample:** reset, then `tx_rdy`=1 and `smp_data`=10'h2AB for one cycle.
  - Expect two `tx_wreq` pulses: `tx_wdata`=6'h35 then 6'h0B.
  - Expect the first pulse 3 cycles after the strobe.
- **Back-pressure:** hold `tx_rdy`=0 after the first pulse for 50 cycles, then raise it.
  - Expect no `tx_wreq` while `tx_rdy`=0.
  - Expect the second character 1 cycle after `tx_rdy` rises.
- **Burst and overflow:** keep `tx_rdy`=0 and strobe 6 samples, 10'h000…10'h005, on consecutive cycles.
  - Expect `fifo_level` to peak at 4 (first popped into shift register) and `ovf_cnt`=1.
  - Then release `tx_rdy`: the characters come out in order 6'h20,6'h00, 6'h20,6'h01, … with no reordering.
- **Push while full with simultaneous pop:** with the FIFO full, present `smp_valid` on the same cycle the FSM pops.
  - Expect the sample to be accepted, `ovf_cnt` unchanged, and the level to stay at 4.
- **Mid-transfer reset:** assert `rst` for 1 cycle in ISSUE.
  - Expect `tx_wreq`=0 next cycle, `fifo_level`=0, `ovf_cnt`=0.
  - Expect the next strobed sample to transmit normally.
- **Full-scale sample:** send `smp_data`=10'h3FF.
  - Expect characters 6'h3F then 6'h1F.
